// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for a dual-write-port register file: grants up to two
// valid/ready requests per cycle in round-robin order and drives the ports from registers.
module regfile_wb_arbiter #(
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_hold,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*REG_AW-1:0] src_rd,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic                    RegWrite,
    output logic [REG_AW-1:0]       Write_register,
    output logic [DATA_W-1:0]       Write_data,
    output logic [REG_AW-1:0]       Write_register2,
    output logic [DATA_W-1:0]       Write_data2,
    output logic [31:0]             pending_mask,
    output logic [31:0]             write_count
);

    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [REG_AW-1:0] rd_arr   [N_SRC];
    logic [DATA_W-1:0] data_arr [N_SRC];

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              arb_en;
    logic              g1;
    logic              g2;
    logic [PTR_W-1:0]  i1;
    logic [PTR_W-1:0]  i2;
    logic [1:0]        gcnt;
    logic [REG_AW-1:0] wr1_nxt;
    logic [REG_AW-1:0] wr2_nxt;
    logic [DATA_W-1:0] wd1_nxt;
    logic [DATA_W-1:0] wd2_nxt;
    logic [31:0]       mask_nxt;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
        assign rd_arr[gi]   = src_rd[gi*REG_AW +: REG_AW];
        assign data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
    end

    // Source index base+off folded back into 0..N_SRC-1 (off < N_SRC).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W-1:0] off);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(off);
        if (sum >= SUM_W'(N_SRC)) begin
            sum = sum - SUM_W'(N_SRC);
        end
        return PTR_W'(sum);
    endfunction

    assign arb_en = !reset && !wb_hold;

    // Round-robin scan: first nonzero-rd requester takes port 1, next one with a different rd takes port 2.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        g1        = 1'b0;
        g2        = 1'b0;
        i1        = '0;
        i2        = '0;
        src_ready = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            idx = wrap_idx(rr_ptr, PTR_W'(k));
            if (arb_en && src_valid[idx]) begin
                if (rd_arr[idx] == '0) begin
                    src_ready[idx] = 1'b1;
                end else if (!g1) begin
                    g1             = 1'b1;
                    i1             = idx;
                    src_ready[idx] = 1'b1;
                end else if (!g2 && (rd_arr[idx] != rd_arr[i1])) begin
                    g2             = 1'b1;
                    i2             = idx;
                    src_ready[idx] = 1'b1;
                end
            end
        end
    end

    // Next port drive, pending mask, grant count and pointer.
    always_comb begin
        wr1_nxt  = '0;
        wd1_nxt  = '0;
        wr2_nxt  = '0;
        wd2_nxt  = '0;
        mask_nxt = '0;
        ptr_nxt  = rr_ptr;
        gcnt     = {1'b0, g1} + {1'b0, g2};
        if (g1) begin
            wr1_nxt           = rd_arr[i1];
            wd1_nxt           = data_arr[i1];
            mask_nxt[wr1_nxt] = 1'b1;
            ptr_nxt           = wrap_idx(i1, PTR_W'(1));
        end
        if (g2) begin
            wr2_nxt           = rd_arr[i2];
            wd2_nxt           = data_arr[i2];
            mask_nxt[wr2_nxt] = 1'b1;
            ptr_nxt           = wrap_idx(i2, PTR_W'(1));
        end
        mask_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite        <= 1'b0;
            Write_register  <= '0;
            Write_data      <= '0;
            Write_register2 <= '0;
            Write_data2     <= '0;
            pending_mask    <= '0;
            write_count     <= '0;
            rr_ptr          <= '0;
        end else begin
            RegWrite        <= g1;
            Write_register  <= wr1_nxt;
            Write_data      <= wd1_nxt;
            Write_register2 <= wr2_nxt;
            Write_data2     <= wd2_nxt;
            pending_mask    <= mask_nxt;
            write_count     <= write_count + 32'(gcnt);
            rr_ptr          <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against
// a queue-free behavioural model of the write-back scheduling rules.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_hold;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_rd;
    logic [N*DW-1:0] src_data;
    logic            RegWrite;
    logic [AW-1:0]   Write_register;
    logic [DW-1:0]   Write_data;
    logic [AW-1:0]   Write_register2;
    logic [DW-1:0]   Write_data2;
    logic [31:0]     pending_mask;
    logic [31:0]     write_count;

    int checks   = 0;
    int failures = 0;

    // Model state
    int            m_ptr;
    int unsigned   m_count;
    logic [N-1:0]  mr;
    int            mg_n;
    int            mg [2];
    logic          exp_we;
    logic [AW-1:0] exp_wr1, exp_wr2;
    logic [DW-1:0] exp_wd1, exp_wd2;
    logic [31:0]   exp_mask;
    logic [DW-1:0] rf_model [32];
    logic [DW-1:0] tb_rf    [32];

    regfile_wb_arbiter #(.N_SRC(N), .DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .wb_hold(wb_hold),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rd(src_rd), .src_data(src_data),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .Write_register2(Write_register2), .Write_data2(Write_data2),
        .pending_mask(pending_mask), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT's write ports.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) tb_rf[r] <= '0;
        end else if (RegWrite) begin
            tb_rf[Write_register] <= Write_data;
            if (Write_register2 != '0) tb_rf[Write_register2] <= Write_data2;
        end
    end

    function automatic logic [AW-1:0] get_rd(input int i);
        return src_rd[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] get_data(input int i);
        return src_data[i*DW +: DW];
    endfunction

    // Which sources the rules accept this cycle, and which take ports 1/2.
    function automatic void model_arb();
        mr    = '0;
        mg_n  = 0;
        mg[0] = 0;
        mg[1] = 0;
        if (reset || wb_hold) return;
        for (int i = 0; i < N; i++)
            if (src_valid[i] && get_rd(i) == '0) mr[i] = 1'b1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (src_valid[j] && get_rd(j) != '0 && mg_n < 2 &&
                (mg_n == 0 || get_rd(j) != get_rd(mg[0]))) begin
                mg[mg_n] = j;
                mg_n++;
                mr[j] = 1'b1;
            end
        end
    endfunction

    // At a clock edge: the previously shown write commits, the new grants become visible.
    function automatic void model_commit();
        if (exp_we) begin
            rf_model[exp_wr1] = exp_wd1;
            if (exp_wr2 != '0) rf_model[exp_wr2] = exp_wd2;
        end
        exp_we   = (mg_n > 0);
        exp_wr1  = (mg_n > 0) ? get_rd(mg[0]) : '0;
        exp_wd1  = (mg_n > 0) ? get_data(mg[0]) : '0;
        exp_wr2  = (mg_n > 1) ? get_rd(mg[1]) : '0;
        exp_wd2  = (mg_n > 1) ? get_data(mg[1]) : '0;
        exp_mask = '0;
        if (mg_n > 0) exp_mask[exp_wr1] = 1'b1;
        if (mg_n > 1) exp_mask[exp_wr2] = 1'b1;
        m_count += 32'(mg_n);
        if (mg_n > 0) m_ptr = (mg[mg_n-1] + 1) % N;
    endfunction

    task automatic tick();
        model_arb();
        @(posedge clk);
        model_commit();
        #1;
        src_valid = src_valid & ~mr;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        src_valid[i]         = 1'b1;
        src_rd[i*AW +: AW]   = rd;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        wb_hold   = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_ptr    = 0;
        m_count  = 0;
        mr       = '0;
        mg_n     = 0;
        exp_we   = 1'b0;
        exp_wr1  = '0;
        exp_wr2  = '0;
        exp_wd1  = '0;
        exp_wd2  = '0;
        exp_mask = '0;
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        wb_hold = 1'b0;
        set_src(0, 5'd1, 32'h1);
        set_src(1, 5'd2, 32'h2);
        set_src(2, 5'd3, 32'h3);
        #2;
        checks++;
        if (src_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 000", src_ready);
        end
        do_reset();
        checks++;
        if ({RegWrite, Write_register, Write_data, Write_register2, Write_data2, pending_mask, write_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b wr=%0d wr2=%0d mask=%h cnt=%0d expected all 0",
                     RegWrite, Write_register, Write_register2, pending_mask, write_count);
        end
        // Reset landing mid-cycle while a write is on the ports.
        set_src(0, 5'd9, 32'h0BAD_F00D);
        tick();
        checks++;
        if (RegWrite !== 1'b1 || write_count !== 32'd1) begin
            failures++;
            $display("FAIL midwrite_setup: got we=%b cnt=%0d expected we=1 cnt=1", RegWrite, write_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({RegWrite, Write_register, Write_data, Write_register2, Write_data2, pending_mask, write_count} !== '0) begin
            failures++;
            $display("FAIL async_reset: got we=%b wr=%0d wd=%h mask=%h cnt=%0d expected all 0",
                     RegWrite, Write_register, Write_data, pending_mask, write_count);
        end
        do_reset();
        tick();
        checks++;
        if (tb_rf[9] !== 32'h0) begin
            failures++;
            $display("FAIL reset_drops_write: got RF[9]=%h expected 0", tb_rf[9]);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_src(0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b001) begin
            failures++;
            $display("FAIL single_ready: got %b expected 001", src_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || Write_register !== 5'd5 || Write_data !== 32'hDEADBEEF ||
            Write_register2 !== 5'd0 || Write_data2 !== 32'h0 || pending_mask !== 32'h20) begin
            failures++;
            $display("FAIL single_ports: got we=%b wr=%0d wd=%h wr2=%0d mask=%h expected we=1 wr=5 wd=deadbeef wr2=0 mask=00000020",
                     RegWrite, Write_register, Write_data, Write_register2, pending_mask);
        end
        tick();
        checks++;
        if (tb_rf[5] !== 32'hDEADBEEF || write_count !== 32'd1 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL single_commit: got RF[5]=%h cnt=%0d we=%b expected deadbeef 1 0",
                     tb_rf[5], write_count, RegWrite);
        end
    endtask

    task automatic test_dual_grant();
        do_reset();
        set_src(0, 5'd1, 32'h11);
        set_src(1, 5'd2, 32'h22);
        set_src(2, 5'd3, 32'h33);
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b011) begin
            failures++;
            $display("FAIL dual_ready1: got %b expected 011", src_ready);
        end
        tick();
        checks++;
        if ({Write_register, Write_data, Write_register2, Write_data2} !== {5'd1, 32'h11, 5'd2, 32'h22} ||
            pending_mask !== 32'h6) begin
            failures++;
            $display("FAIL dual_ports1: got wr=%0d wd=%h wr2=%0d wd2=%h mask=%h expected 1 11 2 22 mask 6",
                     Write_register, Write_data, Write_register2, Write_data2, pending_mask);
        end
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b100) begin
            failures++;
            $display("FAIL dual_ready2: got %b expected 100", src_ready);
        end
        tick();
        checks++;
        if ({RegWrite, Write_register, Write_data, Write_register2} !== {1'b1, 5'd3, 32'h33, 5'd0}) begin
            failures++;
            $display("FAIL dual_ports2: got we=%b wr=%0d wd=%h wr2=%0d expected 1 3 33 0",
                     RegWrite, Write_register, Write_data, Write_register2);
        end
        tick();
        checks++;
        if (write_count !== 32'd3) begin
            failures++;
            $display("FAIL dual_count: got %0d expected 3", write_count);
        end
    endtask

    task automatic test_same_rd();
        do_reset();
        set_src(0, 5'd7, 32'hAAAA_0001);
        set_src(1, 5'd7, 32'hBBBB_0002);
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b001) begin
            failures++;
            $display("FAIL samerd_ready1: got %b expected 001", src_ready);
        end
        tick();
        checks++;
        if ({Write_register, Write_data, Write_register2} !== {5'd7, 32'hAAAA_0001, 5'd0}) begin
            failures++;
            $display("FAIL samerd_ports1: got wr=%0d wd=%h wr2=%0d expected 7 aaaa0001 0",
                     Write_register, Write_data, Write_register2);
        end
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b010) begin
            failures++;
            $display("FAIL samerd_ready2: got %b expected 010", src_ready);
        end
        tick();
        tick();
        checks++;
        if (tb_rf[7] !== 32'hBBBB_0002) begin
            failures++;
            $display("FAIL samerd_final: got RF[7]=%h expected bbbb0002", tb_rf[7]);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_src(1, 5'd0, 32'h1234);
        @(negedge clk);
        checks++;
        if (src_ready !== 3'b010) begin
            failures++;
            $display("FAIL rd0_ready: got %b expected 010", src_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || write_count !== 32'd0 || pending_mask !== 32'h0) begin
            failures++;
            $display("FAIL rd0_noop: got we=%b cnt=%0d mask=%h expected 0 0 0", RegWrite, write_count, pending_mask);
        end
        set_src(0, 5'd0, 32'h5678);
        tick();
        // Pointer must still be 0, so source 0 takes port 1.
        set_src(0, 5'd4, 32'h44);
        set_src(1, 5'd6, 32'h66);
        tick();
        checks++;
        if ({Write_register, Write_register2, write_count} !== {5'd4, 5'd6, 32'd2}) begin
            failures++;
            $display("FAIL rd0_ptr: got wr=%0d wr2=%0d cnt=%0d expected 4 6 2",
                     Write_register, Write_register2, write_count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_src(0, 5'd1, 32'h1);
        tick();
        wb_hold = 1'b1;
        set_src(0, 5'd10, 32'hA0);
        set_src(1, 5'd11, 32'hA1);
        set_src(2, 5'd12, 32'hA2);
        checks++;
        if (RegWrite !== 1'b1 || Write_register !== 5'd1) begin
            failures++;
            $display("FAIL hold_first_cycle: got we=%b wr=%0d expected 1 1", RegWrite, Write_register);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (src_ready !== 3'b000) begin
                failures++;
                $display("FAIL hold_ready_c%0d: got %b expected 000", c, src_ready);
            end
            if (c == 2) wb_hold = 1'b0;
            if (c == 2) break;
            tick();
            checks++;
            if (RegWrite !== 1'b0 || pending_mask !== 32'h0) begin
                failures++;
                $display("FAIL hold_idle_c%0d: got we=%b mask=%h expected 0 0", c, RegWrite, pending_mask);
            end
        end
        #1;
        checks++;
        if (src_ready !== 3'b110) begin
            failures++;
            $display("FAIL hold_resume_ready: got %b expected 110", src_ready);
        end
        tick();
        checks++;
        if ({RegWrite, Write_register, Write_register2, write_count} !== {1'b1, 5'd11, 5'd12, 32'd3}) begin
            failures++;
            $display("FAIL hold_resume_ports: got we=%b wr=%0d wr2=%0d cnt=%0d expected 1 11 12 3",
                     RegWrite, Write_register, Write_register2, write_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && $urandom_range(0, 99) < 60) begin
                    if ($urandom_range(0, 4) == 0) set_src(i, AW'($urandom_range(0, 31)), $urandom);
                    else set_src(i, AW'($urandom_range(0, 7)), $urandom);
                end
            end
            wb_hold = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            model_arb();
            checks++;
            if (src_ready !== mr) begin
                failures++;
                $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, src_ready, mr);
            end
            tick();
            checks++;
            if ({RegWrite, Write_register, Write_data, Write_register2, Write_data2} !==
                {exp_we, exp_wr1, exp_wd1, exp_wr2, exp_wd2}) begin
                failures++;
                $display("FAIL rand_ports cyc%0d: got we=%b %0d:%h %0d:%h expected we=%b %0d:%h %0d:%h", cyc,
                         RegWrite, Write_register, Write_data, Write_register2, Write_data2,
                         exp_we, exp_wr1, exp_wd1, exp_wr2, exp_wd2);
            end
            checks++;
            if (pending_mask !== exp_mask || write_count !== m_count) begin
                failures++;
                $display("FAIL rand_mask_count cyc%0d: got mask=%h cnt=%0d expected mask=%h cnt=%0d",
                         cyc, pending_mask, write_count, exp_mask, m_count);
            end
        end
        wb_hold = 1'b0;
        for (int c = 0; c < 10 && src_valid != '0; c++) tick();
        checks++;
        if (src_valid != '0) begin
            failures++;
            $display("FAIL rand_drain: got pending sources %b expected 000 within 10 cycles", src_valid);
        end
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (tb_rf[r] !== rf_model[r]) begin
                failures++;
                $display("FAIL rand_rf r%0d: got %h expected %h", r, tb_rf[r], rf_model[r]);
            end
        end
    endtask

    initial begin
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        test_reset();
        test_single();
        test_dual_grant();
        test_same_rd();
        test_rd_zero();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
